sw_test_status_tracker: RTL and testbench
=========================================

// Module: sw_test_status_tracker
// PURPOSE
// - Synthesizable consumer of the SW test-status protocol. Snoops CPU writes to the test-status address
//   and decodes each 16-bit code. Tracks the test lifecycle in an FSM and reports pass/fail/done.
// - Flags illegal codes and illegal orderings; optional watchdog catches a hung test.
// - Sits beside the status-write endpoint in top_earlgrey; feeds DV/FPGA end-of-test logic.
// PARAMETERS
// - AddrWidth      32              width of wr_addr_i
// - StatusAddr     32'h0041_1000   word address matched for status writes (full-width compare)
// - TimeoutCycles  32'd1_000_000   watchdog limit in clk_i cycles; must be >= 1 (used only with macro)
// PORTS
// - clk_i                  in   1          single clock
// - rst_ni                 in   1          async active-low reset
// - wr_valid_i             in   1          write strobe, one write per high cycle; always accepted
// - wr_addr_i              in   AddrWidth  write address
// - wr_data_i              in   32         write data; only [15:0] decoded, [31:16] ignored
// - status_o               out  16         last legal code accepted (reset 16'h0000)
// - test_done_o            out  1          sticky: Passed, Failed or timeout reached (reset 0)
// - test_passed_o          out  1          state==Passed && !err_code_o && !err_order_o && !timeout_o (reset 0)
// - test_failed_o          out  1          done && !test_passed_o (reset 0)
// - err_code_o             out  1          sticky: matched write with undefined code (reset 0)
// - err_order_o            out  1          sticky: legal code in illegal order (reset 0)
// - timeout_o              out  1          sticky watchdog expiry; tied 0 without macro (reset 0)
// BEHAVIOUR
// - Decoded codes:
//   - UnderReset 0000, Booted b004, InBootRom b090, InTest 4354, InWfi 1d1e
//   - Passed 900d, Failed baad
// - Accepted write: wr_valid_i && wr_addr_i==StatusAddr. All outputs are registered.
//   - Write sampled at edge N updates status_o and flags at edge N (visible in cycle N+1).
// - FSM states equal the codes; reset state UnderReset.
//   - Legal moves: UnderReset->Booted->InBootRom->InTest. InTest<->InWfi.
//   - InTest|InWfi->Passed. Any non-terminal->Failed. Same-code rewrite is legal (no-op).
// - Undefined code: state and status_o unchanged; err_code_o set.
// - Legal code, illegal move:
//   - State still moves to the written code and err_order_o is set.
//   - A write of UnderReset from any other state counts as an illegal move.
// - Terminal (Passed/Failed): all further writes ignored; no flag change, even for undefined codes.
// - test_done_o rises the same cycle state enters Passed/Failed; never clears except on rst_ni.
// - Non-matching addresses are ignored entirely.
// - rst_ni assertion mid-test: async clear of all state, flags and counter. Test restarts at UnderReset.
// CONFIGURATION
// - SW_TEST_STATUS_TIMEOUT_EN defined:
//   - 32-bit cycle counter, cleared on every accepted legal write.
//   - Counts while state not in {UnderReset, Passed, Failed}; saturates at TimeoutCycles.
//   - At count==TimeoutCycles-1 with no write that cycle, timeout_o and test_done_o set next edge.
//   - After timeout, writes are still decoded, but done stays set and passed stays 0.
//   - A write in the expiry cycle wins: counter clears, no timeout.
// - Macro undefined: no counter logic; timeout_o constant 0.
// TESTING
// - Write b004,b090,4354,900d to StatusAddr, one per cycle:
//   - status_o follows each code 1 cycle later.
//   - done=1, passed=1, failed=0, errs=0.
// - Write b004,b090,4354,1d1e,4354,1d1e,4354,900d -> passed=1, err_order_o=0.
// - Write b004 then 1234:
//   - err_code_o=1, status_o stays b004.
//   - Later 4354 sets err_order_o=1. 900d -> done=1, failed=1.
// - After 900d, write baad and 5555 -> status_o stays 900d, err flags unchanged.
// - Write b004 to StatusAddr+4 -> status_o stays 0000.
//   - Write baad from UnderReset -> done=1, failed=1, err_order_o=0.
// - Macro on, TimeoutCycles=16:
//   - b004, then idle 16 cycles -> timeout_o=1, done=1, failed=1.
//   - Pulse rst_ni low mid-test -> all outputs 0.

Source files
------------

// File: rtl/sw_test_status_tracker.sv
// Snoops CPU writes to the SW test-status address, tracks the test lifecycle and reports pass/fail/done.
// Optional watchdog enabled by defining SW_TEST_STATUS_TIMEOUT_EN.
module sw_test_status_tracker #(
   parameter int unsigned          AddrWidth     = 32,
   parameter logic [AddrWidth-1:0] StatusAddr    = 32'h0041_1000,
   parameter logic [31:0]          TimeoutCycles = 32'd1_000_000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wr_valid_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [31:0]          wr_data_i,
   output logic [15:0]          status_o,
   output logic                 test_done_o,
   output logic                 test_passed_o,
   output logic                 test_failed_o,
   output logic                 err_code_o,
   output logic                 err_order_o,
   output logic                 timeout_o
);

   localparam logic [15:0] UNDER_RESET = 16'h0000;
   localparam logic [15:0] BOOTED      = 16'hb004;
   localparam logic [15:0] IN_BOOT_ROM = 16'hb090;
   localparam logic [15:0] IN_TEST     = 16'h4354;
   localparam logic [15:0] IN_WFI      = 16'h1d1e;
   localparam logic [15:0] PASSED      = 16'h900d;
   localparam logic [15:0] FAILED      = 16'hbaad;

   function automatic logic is_defined_code(input logic [15:0] code);
      logic ok;
      case (code)
         UNDER_RESET, BOOTED, IN_BOOT_ROM, IN_TEST,
         IN_WFI, PASSED, FAILED: ok = 1'b1;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Same-code rewrites are no-ops; any non-terminal state may jump to FAILED.
   function automatic logic is_legal_move(input logic [15:0] cur, input logic [15:0] nxt);
      logic ok;
      if (nxt == cur) begin
         ok = 1'b1;
      end else begin
         case (cur)
            UNDER_RESET: ok = (nxt == BOOTED)      || (nxt == FAILED);
            BOOTED:      ok = (nxt == IN_BOOT_ROM) || (nxt == FAILED);
            IN_BOOT_ROM: ok = (nxt == IN_TEST)     || (nxt == FAILED);
            IN_TEST:     ok = (nxt == IN_WFI)  || (nxt == PASSED) || (nxt == FAILED);
            IN_WFI:      ok = (nxt == IN_TEST) || (nxt == PASSED) || (nxt == FAILED);
            default:     ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   logic [15:0] state_r, state_nx_s;
   logic        done_r, done_nx_s;
   logic        passed_r, passed_nx_s;
   logic        failed_r, failed_nx_s;
   logic        err_code_r, err_code_nx_s;
   logic        err_order_r, err_order_nx_s;
   logic        timeout_r, timeout_nx_s;
   logic        accept_s, terminal_s, legal_wr_s;
   logic [15:0] code_s;

   assign accept_s   = wr_valid_i && (wr_addr_i == StatusAddr);
   assign code_s     = wr_data_i[15:0];
   assign terminal_s = (state_r == PASSED) || (state_r == FAILED);

   // Decode the snooped write into next state and sticky error flags.
   always_comb begin
      state_nx_s     = state_r;
      err_code_nx_s  = err_code_r;
      err_order_nx_s = err_order_r;
      legal_wr_s     = 1'b0;
      if (accept_s && !terminal_s) begin
         if (is_defined_code(code_s)) begin
            legal_wr_s = 1'b1;
            state_nx_s = code_s;
            if (!is_legal_move(state_r, code_s)) begin
               err_order_nx_s = 1'b1;
            end else begin
               err_order_nx_s = err_order_r;
            end
         end else begin
            err_code_nx_s = 1'b1;
         end
      end else begin
         legal_wr_s = 1'b0;
      end
   end

`ifdef SW_TEST_STATUS_TIMEOUT_EN
   logic [31:0] cnt_r, cnt_nx_s;
   logic        counting_s;
   logic        unused_s;

   assign counting_s = (state_r != UNDER_RESET) && !terminal_s;
   assign unused_s   = ^wr_data_i[31:16];

   // Watchdog: a legal write in the expiry cycle clears the counter and prevents the timeout.
   always_comb begin
      cnt_nx_s     = cnt_r;
      timeout_nx_s = timeout_r;
      if (legal_wr_s) begin
         cnt_nx_s = 32'd0;
      end else if (counting_s && (cnt_r != TimeoutCycles)) begin
         cnt_nx_s = cnt_r + 32'd1;
      end else begin
         cnt_nx_s = cnt_r;
      end
      if (counting_s && !legal_wr_s && (cnt_r == TimeoutCycles - 32'd1)) begin
         timeout_nx_s = 1'b1;
      end else begin
         timeout_nx_s = timeout_r;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= 32'd0;
      end else begin
         cnt_r <= cnt_nx_s;
      end
   end
`else
   logic unused_s;

   assign unused_s = (^wr_data_i[31:16]) ^ (^TimeoutCycles) ^ legal_wr_s;

   // No watchdog in this build.
   always_comb begin
      timeout_nx_s = 1'b0;
   end
`endif

   // Result outputs are computed from next-state values so they register alongside the state.
   always_comb begin
      done_nx_s   = done_r || (state_nx_s == PASSED) || (state_nx_s == FAILED) || timeout_nx_s;
      passed_nx_s = (state_nx_s == PASSED) && !err_code_nx_s && !err_order_nx_s && !timeout_nx_s;
      failed_nx_s = done_nx_s && !passed_nx_s;
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= UNDER_RESET;
         done_r      <= 1'b0;
         passed_r    <= 1'b0;
         failed_r    <= 1'b0;
         err_code_r  <= 1'b0;
         err_order_r <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         done_r      <= done_nx_s;
         passed_r    <= passed_nx_s;
         failed_r    <= failed_nx_s;
         err_code_r  <= err_code_nx_s;
         err_order_r <= err_order_nx_s;
         timeout_r   <= timeout_nx_s;
      end
   end

   assign status_o      = state_r;
   assign test_done_o   = done_r;
   assign test_passed_o = passed_r;
   assign test_failed_o = failed_r;
   assign err_code_o    = err_code_r;
   assign err_order_o   = err_order_r;
   assign timeout_o     = timeout_r;

endmodule

// File: tb/tb_sw_test_status_tracker.sv
// Directed table-driven bench for sw_test_status_tracker, plus hand sequences for watchdog and reset.
module tb_sw_test_status_tracker;

   localparam logic [31:0] A = 32'h0041_1000;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        wr_valid_i = 1'b0;
   logic [31:0] wr_addr_i = 32'd0;
   logic [31:0] wr_data_i = 32'd0;
   logic [15:0] status_o;
   logic        test_done_o, test_passed_o, test_failed_o;
   logic        err_code_o, err_order_o, timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   sw_test_status_tracker #(
      .AddrWidth    (32),
      .StatusAddr   (A),
      .TimeoutCycles(32'd16)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wr_valid_i   (wr_valid_i),
      .wr_addr_i    (wr_addr_i),
      .wr_data_i    (wr_data_i),
      .status_o     (status_o),
      .test_done_o  (test_done_o),
      .test_passed_o(test_passed_o),
      .test_failed_o(test_failed_o),
      .err_code_o   (err_code_o),
      .err_order_o  (err_order_o),
      .timeout_o    (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] st;
      logic        done, pass, fail, ec, eo;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic valid, input logic [31:0] addr,
                               input logic [31:0] data, input logic [15:0] st, input logic done,
                               input logic pass, input logic fail, input logic ec, input logic eo);
      vec_t v;
      v.rst = rst; v.valid = valid; v.addr = addr; v.data = data; v.st = st;
      v.done = done; v.pass = pass; v.fail = fail; v.ec = ec; v.eo = eo;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] st, input logic done, input logic pass,
                            input logic fail, input logic ec, input logic eo, input logic to);
      check({tag, " status"}, 32'(status_o), 32'(st));
      check({tag, " done"}, 32'(test_done_o), 32'(done));
      check({tag, " passed"}, 32'(test_passed_o), 32'(pass));
      check({tag, " failed"}, 32'(test_failed_o), 32'(fail));
      check({tag, " err_code"}, 32'(err_code_o), 32'(ec));
      check({tag, " err_order"}, 32'(err_order_o), 32'(eo));
      check({tag, " timeout"}, 32'(timeout_o), 32'(to));
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      #2;
   endtask

   task automatic wr(input logic valid, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk_i);
      wr_valid_i = valid;
      wr_addr_i  = addr;
      wr_data_i  = data;
      @(posedge clk_i);
      #1;
      wr_valid_i = 1'b0;
   endtask

   initial begin
      // rst, valid, addr, data, status, done, pass, fail, err_code, err_order
      add(1'b1, 1'b0, A, 32'h0,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // nominal boot to pass
      add(1'b0, 1'b1, A, 32'hb004, 16'hb004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'hb090, 16'hb090, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h4354, 16'h4354, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h900d, 16'h900d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, A, 32'h0,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // wfi round trips
      add(1'b0, 1'b1, A, 32'hb004, 16'hb004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'hb090, 16'hb090, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h4354, 16'h4354, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h1d1e, 16'h1d1e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h4354, 16'h4354, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h1d1e, 16'h1d1e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h4354, 16'h4354, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h900d, 16'h900d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, A, 32'h0,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // bad code, bad order, then terminal writes ignored
      add(1'b0, 1'b1, A, 32'hb004, 16'hb004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h1234, 16'hb004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b0, A, 32'h4354, 16'hb004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, A, 32'h4354, 16'h4354, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b1, A, 32'h900d, 16'h900d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      add(1'b0, 1'b1, A, 32'hbaad, 16'h900d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      add(1'b0, 1'b1, A, 32'h5555, 16'h900d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      add(1'b1, 1'b0, A, 32'h0,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // wrong address ignored; fail straight from reset is a legal move
      add(1'b0, 1'b1, A + 32'd4, 32'hb004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'hbaad, 16'hbaad, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, A, 32'h0,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // upper data bits ignored; UnderReset rewrite from Booted is an order error
      add(1'b0, 1'b1, A, 32'hffff_b004, 16'hb004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, A, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, A, 32'h0000_b004, 16'hb004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // skip ahead to Passed: state moves, but result is a failure
      add(1'b0, 1'b1, A, 32'h0000_900d, 16'h900d, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      // async reset mid-test clears everything
      add(1'b1, 1'b0, A, 32'h0,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) begin
            pulse_reset();
         end else begin
            wr(vecs[i].valid, vecs[i].addr, vecs[i].data);
         end
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].done, vecs[i].pass,
                   vecs[i].fail, vecs[i].ec, vecs[i].eo, 1'b0);
         rst_ni = 1'b1;
      end

`ifdef SW_TEST_STATUS_TIMEOUT_EN
      // watchdog expires 16 idle cycles after the last legal write
      pulse_reset();
      rst_ni = 1'b1;
      wr(1'b1, A, 32'hb004);
      for (int k = 0; k < 15; k++) wr(1'b0, A, 32'h0);
      check_all("to_before", 16'hb004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wr(1'b0, A, 32'h0);
      check_all("to_expire", 16'hb004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      wr(1'b1, A, 32'hb090);
      check_all("to_after_wr", 16'hb090, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      // a legal write in the expiry cycle wins
      pulse_reset();
      rst_ni = 1'b1;
      wr(1'b1, A, 32'hb004);
      for (int k = 0; k < 15; k++) wr(1'b0, A, 32'h0);
      wr(1'b1, A, 32'hb090);
      check_all("to_saved", 16'hb090, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 15; k++) wr(1'b0, A, 32'h0);
      check_all("to_saved_idle", 16'hb090, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse_reset();
      check_all("to_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_ni = 1'b1;
`else
      // no watchdog: a long idle never times out
      pulse_reset();
      rst_ni = 1'b1;
      wr(1'b1, A, 32'hb004);
      for (int k = 0; k < 40; k++) wr(1'b0, A, 32'h0);
      check_all("no_to", 16'hb004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
